freq_display: RTL and testbench
===============================

# freq_display

Converts the 20-bit measured frequency from the frequency counter into six BCD digits and drives a multiplexed, common-anode 6-digit 7-segment display. Sits directly downstream of the frequency counter in the `clk_sys` domain. Uses an iterative double-dabble converter, a display latch that updates atomically, and a digit-scan multiplexer with leading-zero blanking.

## Interface
- `SCAN_DIV`, default 2000: `clk_sys` cycles per digit slot; 12 MHz/2000 gives a 6 kHz digit rate and a 1 kHz frame rate. Legal range 2..65535.
- `clk_sys`  in  1  12 MHz system clock; the only clock.
- `rst`  in  1  reset, synchronous and active-high.
- `freq_value`  in  20  measured frequency in Hz, from the `clk_sys` domain.
- `seg_n`  out  8  segments, active-low; [0]=a … [6]=g, [7]=dp.
- `dig_n`  out  6  digit enables, active-low, one-hot; [0]=units … [5]=hundred-thousands.
- `ovf`  out  1  high while the displayed value was clamped.
- `busy`  out  1  high while a conversion is in progress.
- `upd`  out  1  one-cycle pulse when the display latch is written.

## Operation
- Registers:
  - `last_val[19:0]`: last accepted input.
  - `sh[19:0]`, `bcd[23:0]`: double-dabble working registers.
  - `it[4:0]`: iteration counter.
  - `disp[23:0]`: display latch.
  - `ovf`.
  - `pre[15:0]`: scan prescaler.
  - `idx[2:0]`: current digit slot.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - If `freq_value != last_val`: `last_val <= freq_value`, `sh <= min(freq_value, 999999)`, `ovf_next <= (freq_value > 999999)`, `bcd <= 0`, `it <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per clock:
  - Add 3 to each BCD nibble that is >= 5.
  - Shift `{bcd,sh}` left by 1.
  - `it++`.
  - After the iteration with `it==19`, go to DONE.
- DONE:
  - `disp <= bcd`, `ovf <= ovf_next`, `upd <= 1` for this cycle, go to IDLE.
- Input changes during SHIFT or DONE are ignored. They are caught on the first IDLE cycle by the `last_val` compare, so the last value always wins.
- `busy = (state != IDLE)`.
- Scan:
  - `pre` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, `idx` advances 0→1→…→5→0.
- Digit decode, with `d = disp[4*idx +: 4]`:
  - Active-low patterns 0–9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90.
  - Any nibble 10–15 (illegal): BF (g only).
  - `dp` is always off (bit 7 = 1).
- Leading-zero blanking: slot k>0 is blanked (`seg_n = FF`) when `disp` nibbles k..5 are all zero. Slot 0 is never blanked.
- `dig_n = ~(1 << idx)`; the enable is still driven for blanked slots.

## Timing
- `seg_n` and `dig_n` are registered from the current `idx` and `disp`, so they lag `idx` by one cycle.
- Reset values, taking effect on the `rst` edge:
  - state IDLE; `last_val`, `disp`, `bcd`, `sh`, `it`, `pre`, `idx` = 0.
  - `ovf = 0`, `busy = 0`, `upd = 0`.
  - `seg_n = FF`, `dig_n = 3F` (all off).
- First cycle after reset releases: `seg_n = C0`, `dig_n = 3E`.
- Latency, with edge E being the IDLE edge that captures a new input:
  - 20 SHIFT edges follow.
  - `upd` is high and `disp`/`ovf` are written on edge E+21.
  - Outputs reflect the new value from E+22.
  - Minimum re-accept spacing is 22 cycles.
- `rst` asserted mid-conversion aborts the conversion immediately. `disp` returns to 0 and no `upd` is issued.
- `rst` has priority over every other event in the same cycle.
- `freq_value = 0` after reset is not a change, so no conversion runs.
- Each slot is active for exactly SCAN_DIV cycles; a frame is 6·SCAN_DIV cycles.
- `disp` changes only in DONE, so a digit never shows a partially converted value.

## Test plan
- Reset, then hold `rst` low with `freq_value = 0` for 100 cycles:
  - `busy` and `upd` stay 0 throughout.
  - Slot 0 shows `seg_n = C0`; slots 1–5 show FF.
- With `SCAN_DIV = 4`, set `freq_value = 123456`:
  - `upd` pulses exactly 21 cycles after capture.
  - Over one frame the slot/`seg_n` pairs are 0:82, 1:92, 2:99, 3:B0, 4:A4, 5:F9.
  - `ovf = 0`.
- Set `freq_value = 1000000`, then `0xFFFFF`:
  - All six slots show 90 ("999999") and `ovf = 1`.
  - Then set 5: `ovf = 0`, slot 0 shows 92, slots 1–5 show FF.
- Set `freq_value = 100000`: slots 0–4 show C0 (interior zeros not blanked), slot 5 shows F9.
- Set 111111, change to 222222 five cycles later while `busy = 1`:
  - Two `upd` pulses occur, the second 22 cycles after the first.
  - Final display is all A4 ("222222").
- Set 654321, then assert `rst` for one cycle after 10 SHIFT cycles:
  - No `upd` fires.
  - After reset, `disp = 0` and the reset output values hold.
  - With `freq_value` still 654321, a new conversion starts on the first IDLE cycle and completes correctly.

Source files
------------

// File: rtl/freq_display.sv
// Binary-to-BCD conversion of the measured frequency and a multiplexed,
// common-anode six-digit seven-segment driver with leading-zero blanking.
module freq_display #(
  parameter int unsigned SCAN_DIV = 2000
) (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic [19:0] freq_value,
  output logic [7:0]  seg_n,
  output logic [5:0]  dig_n,
  output logic        ovf,
  output logic        busy,
  output logic        upd
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [19:0] MAX_SHOWN = 20'd999999;
  localparam logic [15:0] PRE_LAST  = 16'(SCAN_DIV - 1);

  state_t      state;
  logic [19:0] last_val;
  logic [19:0] sh;
  logic [23:0] bcd;
  logic [23:0] bcd_adj;
  logic [4:0]  it;
  logic [23:0] disp;
  logic        ovf_next;
  logic [15:0] pre;
  logic [2:0]  idx;
  logic [3:0]  digit;
  logic [23:0] disp_hi;
  logic        blank;
  logic [7:0]  seg_pat;

  // NOTE: every variable gets a default before any conditional update so the
  // block stays purely combinational and no latch is inferred.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 6; n++) begin
      if (bcd[4*n +: 4] >= 4'd5) bcd_adj[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state    <= IDLE;
      last_val <= '0;
      sh       <= '0;
      bcd      <= '0;
      it       <= '0;
      disp     <= '0;
      ovf      <= 1'b0;
      ovf_next <= 1'b0;
      upd      <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (freq_value != last_val) begin
            last_val <= freq_value;
            sh       <= (freq_value > MAX_SHOWN) ? MAX_SHOWN : freq_value;
            ovf_next <= (freq_value > MAX_SHOWN);
            bcd      <= '0;
            it       <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, sh} <= {bcd_adj[22:0], sh, 1'b0};
          it        <= it + 5'd1;
          if (it == 5'd19) state <= DONE;
        end
        DONE: begin
          // The latch is written in one go so a half-converted value is never shown.
          disp  <= bcd;
          ovf   <= ovf_next;
          upd   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    digit   = disp[{idx, 2'b00} +: 4];
    disp_hi = disp >> {idx, 2'b00};
    // A slot is blank only when it and every more significant digit are zero.
    blank   = (idx != 3'd0) && (disp_hi == 24'd0);
    case (digit)
      4'd0:    seg_pat = 8'hC0;
      4'd1:    seg_pat = 8'hF9;
      4'd2:    seg_pat = 8'hA4;
      4'd3:    seg_pat = 8'hB0;
      4'd4:    seg_pat = 8'h99;
      4'd5:    seg_pat = 8'h92;
      4'd6:    seg_pat = 8'h82;
      4'd7:    seg_pat = 8'hF8;
      4'd8:    seg_pat = 8'h80;
      4'd9:    seg_pat = 8'h90;
      default: seg_pat = 8'hBF;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      pre   <= '0;
      idx   <= '0;
      seg_n <= 8'hFF;
      dig_n <= 6'h3F;
    end else begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        pre <= pre + 16'd1;
      end
      seg_n <= blank ? 8'hFF : seg_pat;
      dig_n <= ~(6'b000001 << idx);
    end
  end

endmodule

// File: tb/tb_freq_display.sv
// Directed bench for freq_display with a short scan period so whole frames
// can be observed quickly.
module tb_freq_display;

  localparam int unsigned SCAN_DIV = 4;
  localparam int FRAME = 6 * SCAN_DIV;

  logic        clk_sys = 1'b0;
  logic        rst;
  logic [19:0] freq_value;
  logic [7:0]  seg_n;
  logic [5:0]  dig_n;
  logic        ovf;
  logic        busy;
  logic        upd;

  int n_checks = 0;
  int n_errors = 0;
  int upd_seen = 0;
  int busy_seen = 0;

  freq_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .freq_value(freq_value),
    .seg_n     (seg_n),
    .dig_n     (dig_n),
    .ovf       (ovf),
    .busy      (busy),
    .upd       (upd)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (upd === 1'b1)  upd_seen++;
    if (busy === 1'b1) busy_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Returns once busy is seen (the edge that captured the input).
  task automatic wait_capture(input string tag);
    int n = 0;
    while (busy !== 1'b1 && n < 5) begin
      step();
      n++;
    end
    check({tag, "_capture"}, {31'd0, busy}, 32'd1);
  endtask

  // Edges from the current point until upd is observed; -1 on timeout.
  task automatic wait_upd(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      if (upd === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  // Observes one full frame and compares each slot against exp {s5,...,s0}.
  task automatic check_frame(input string tag, input logic [47:0] exp);
    logic [7:0] seg_obs [6];
    int         hits    [6];
    for (int k = 0; k < 6; k++) begin
      seg_obs[k] = 8'hxx;
      hits[k]    = 0;
    end
    for (int c = 0; c < FRAME; c++) begin
      step();
      for (int k = 0; k < 6; k++) begin
        if (dig_n === ~(6'b000001 << k)) begin
          seg_obs[k] = seg_n;
          hits[k]++;
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      check($sformatf("%s_seg%0d", tag, k), {24'd0, seg_obs[k]}, {24'd0, exp[8*k +: 8]});
      check($sformatf("%s_dwell%0d", tag, k), hits[k], SCAN_DIV);
    end
  endtask

  task automatic convert(input string tag, input logic [19:0] val);
    int cyc;
    freq_value = val;
    step();
    wait_capture(tag);
    wait_upd(cyc);
    check({tag, "_lat"}, cyc, 32'd21);
    step();
    check({tag, "_upd_pulse"}, {31'd0, upd}, 32'd0);
  endtask

  initial begin
    int cyc;
    int upd_base;
    rst        = 1'b1;
    freq_value = 20'd0;
    repeat (3) step();
    check("rst_seg", {24'd0, seg_n}, 32'hFF);
    check("rst_dig", {26'd0, dig_n}, 32'h3F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_upd", {31'd0, upd}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);

    rst = 1'b0;
    step();
    check("rel_seg", {24'd0, seg_n}, 32'hC0);
    check("rel_dig", {26'd0, dig_n}, 32'h3E);

    upd_base  = upd_seen;
    busy_seen = 0;
    repeat (100) step();
    check("idle_upd", upd_seen - upd_base, 32'd0);
    check("idle_busy", busy_seen, 32'd0);
    check_frame("zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    convert("v123456", 20'd123456);
    check_frame("v123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});
    check("v123456_ovf", {31'd0, ovf}, 32'd0);

    convert("v1000000", 20'd1000000);
    check_frame("v1000000", {6{8'h90}});
    check("v1000000_ovf", {31'd0, ovf}, 32'd1);

    convert("vFFFFF", 20'hFFFFF);
    check_frame("vFFFFF", {6{8'h90}});
    check("vFFFFF_ovf", {31'd0, ovf}, 32'd1);

    convert("v5", 20'd5);
    check_frame("v5", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h92});
    check("v5_ovf", {31'd0, ovf}, 32'd0);

    convert("v100000", 20'd100000);
    check_frame("v100000", {8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});

    // Input changes mid-conversion: last value wins on the next IDLE cycle.
    freq_value = 20'd111111;
    step();
    wait_capture("v111111");
    repeat (5) step();
    freq_value = 20'd222222;
    check("chg_busy", {31'd0, busy}, 32'd1);
    wait_upd(cyc);
    check("chg_first_lat", cyc, 32'd16);
    wait_upd(cyc);
    check("chg_second_gap", cyc, 32'd22);
    check_frame("v222222", {6{8'hA4}});

    // Reset in the middle of a conversion aborts it.
    upd_base   = upd_seen;
    freq_value = 20'd654321;
    step();
    wait_capture("v654321");
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_seg", {24'd0, seg_n}, 32'hFF);
    check("abort_dig", {26'd0, dig_n}, 32'h3F);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_upd", {31'd0, upd}, 32'd0);
    check("abort_ovf", {31'd0, ovf}, 32'd0);
    check("abort_no_upd", upd_seen - upd_base, 32'd0);
    step();
    check("abort_rel_seg", {24'd0, seg_n}, 32'hC0);
    check("abort_rel_dig", {26'd0, dig_n}, 32'h3E);
    check("abort_restart", {31'd0, busy}, 32'd1);
    wait_upd(cyc);
    check("abort_lat", cyc, 32'd21);
    check_frame("v654321", {8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9});
    check("v654321_ovf", {31'd0, ovf}, 32'd0);
    check("abort_upd_count", upd_seen - upd_base, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
